// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the Ethernet RX to uDMA framing path.
package eth_rx_pkg;

    typedef enum logic [1:0] {
        ST_FRAME   = 2'd0,
        ST_DISCARD = 2'd1,
        ST_STATUS  = 2'd2
    } state_e;

    localparam int ERR_BIT   = 31;
    localparam int TRUNC_BIT = 30;
    localparam int LEN_LSB   = 0;

    localparam logic [1:0] UDMA_SIZE_WORD = 2'b10;

    // Zero every byte lane above the last valid one (byte_count = valid bytes - 1).
    function automatic logic [31:0] mask_lanes(input logic [31:0] data, input logic [1:0] byte_count);
        logic [31:0] res;
        res = '0;
        for (int i = 0; i < 4; i++) begin
            if (2'(i) <= byte_count) begin
                res[8*i +: 8] = data[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/eth_rx_out_reg.sv
// Single-stage valid/ready output register; holds its word while the sink stalls.
module eth_rx_out_reg #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         tag_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         tag_o,
    output logic         load_ok_o
);

    logic         valid_q;
    logic [W-1:0] data_q;
    logic         tag_q;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            tag_q   <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            tag_q   <= tag_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o   = valid_q;
    assign data_o    = data_q;
    assign tag_o     = tag_q;
    assign load_ok_o = !valid_q || ready_i;

endmodule

// File: rtl/eth_rx_udma_framer.sv
// Frames the RX buffer word stream for the uDMA RX channel, appending one status word per frame.
module eth_rx_udma_framer
    import eth_rx_pkg::*;
#(
    parameter int MAX_FRAME_BYTES = 1518,
    parameter int LEN_WIDTH       = 16
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        cfg_en_i,
    input  logic [31:0] s_axis_tdata,
    input  logic [1:0]  s_axis_byte_count,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tuser,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [31:0] data_rx_o,
    output logic [1:0]  data_rx_datasize_o,
    output logic        data_rx_valid_o,
    input  logic        data_rx_ready_i,
    output logic        frame_done_o,
    output logic [15:0] frame_cnt_o,
    output logic [15:0] err_cnt_o,
    output logic [15:0] drop_cnt_o
);

    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_FRAME_BYTES);

    state_e                 state_q, state_d;
    logic                   sof_q, sof_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic                   err_q, err_d;
    logic                   trunc_q, trunc_d;
    logic [15:0]            frame_cnt_q, frame_cnt_d;
    logic [15:0]            err_cnt_q, err_cnt_d;
    logic [15:0]            drop_cnt_q, drop_cnt_d;

    logic                   out_load;
    logic [31:0]            out_data;
    logic                   out_tag;
    logic                   out_tag_q;
    logic                   load_ok;
    logic                   tready_c;
    logic [LEN_WIDTH:0]     len_sum;
    logic [31:0]            status_word;

    always_comb begin
        tready_c = 1'b0;
        case (state_q)
            ST_FRAME:   tready_c = load_ok;
            ST_DISCARD: tready_c = 1'b1;
            default:    tready_c = 1'b0;
        endcase
    end

    // Nothing is accepted while reset is held.
    assign s_axis_tready = tready_c && rstn_i;

    always_comb begin
        len_sum = {1'b0, len_q} + (LEN_WIDTH+1)'(s_axis_byte_count) + (LEN_WIDTH+1)'(1);
        status_word = '0;
        status_word[ERR_BIT]   = err_q;
        status_word[TRUNC_BIT] = trunc_q;
        status_word[LEN_LSB +: LEN_WIDTH] = len_q;
    end

    always_comb begin
        state_d     = state_q;
        sof_d       = sof_q;
        len_d       = len_q;
        err_d       = err_q;
        trunc_d     = trunc_q;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        out_load    = 1'b0;
        out_data    = '0;
        out_tag     = 1'b0;

        case (state_q)
            ST_FRAME: begin
                if (s_axis_tvalid && s_axis_tready) begin
                    if (sof_q && !cfg_en_i) begin
                        if (s_axis_tlast) begin
                            drop_cnt_d = drop_cnt_q + 16'd1;
                        end else begin
                            state_d = ST_DISCARD;
                            sof_d   = 1'b0;
                        end
                    end else begin
                        len_d = len_sum[LEN_WIDTH] ? '1 : len_sum[LEN_WIDTH-1:0];
                        err_d = err_q | s_axis_tuser;
                        // Forwarding is decided on the length before this word is added.
                        if (len_q < MAX_LEN) begin
                            out_load = 1'b1;
                            out_data = mask_lanes(s_axis_tdata, s_axis_byte_count);
                        end else begin
                            trunc_d = 1'b1;
                        end
                        if (s_axis_tlast) begin
                            state_d = ST_STATUS;
                            sof_d   = 1'b1;
                        end else begin
                            sof_d   = 1'b0;
                        end
                    end
                end
            end
            ST_DISCARD: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                    sof_d      = 1'b1;
                    state_d    = ST_FRAME;
                end
            end
            ST_STATUS: begin
                if (load_ok) begin
                    out_load    = 1'b1;
                    out_data    = status_word;
                    out_tag     = 1'b1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    if (err_q || trunc_q) begin
                        err_cnt_d = err_cnt_q + 16'd1;
                    end
                    len_d   = '0;
                    err_d   = 1'b0;
                    trunc_d = 1'b0;
                    state_d = ST_FRAME;
                end
            end
            default: state_d = ST_FRAME;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= ST_FRAME;
            sof_q       <= 1'b1;
            len_q       <= '0;
            err_q       <= 1'b0;
            trunc_q     <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            sof_q       <= sof_d;
            len_q       <= len_d;
            err_q       <= err_d;
            trunc_q     <= trunc_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    eth_rx_out_reg #(.W(32)) u_out_reg (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .load_i    (out_load),
        .data_i    (out_data),
        .tag_i     (out_tag),
        .ready_i   (data_rx_ready_i),
        .valid_o   (data_rx_valid_o),
        .data_o    (data_rx_o),
        .tag_o     (out_tag_q),
        .load_ok_o (load_ok)
    );

    assign data_rx_datasize_o = UDMA_SIZE_WORD;
    assign frame_done_o       = data_rx_valid_o && data_rx_ready_i && out_tag_q;
    assign frame_cnt_o        = frame_cnt_q;
    assign err_cnt_o          = err_cnt_q;
    assign drop_cnt_o         = drop_cnt_q;

endmodule

// File: doc/eth_rx_udma_framer.md
Name: eth_rx_udma_framer

Overview:
- Consumes the 32-bit word stream produced by the Ethernet RX clock-crossing buffer: tdata, 2-bit byte count, tuser, tlast.
- Forwards frame data words to the uDMA RX channel and appends one status word per frame carrying byte length, error and truncation flags.
- Enforces a maximum frame length and discards whole frames while disabled.
- Sits entirely in the uDMA system clock domain, between the RX buffer read side and the uDMA RX channel.

Parameters:
- MAX_FRAME_BYTES, 1518, frame bytes forwarded before truncation (1..65535).
- LEN_WIDTH, 16, width of byte-length counter and status length field.

Ports:
- clk_i  input  1  system clock.
- rstn_i  input  1  synchronous active-low reset.
- cfg_en_i  input  1  enable; sampled only at frame start.
- s_axis_tdata  input  32  frame word, byte 0 in bits [7:0].
- s_axis_byte_count  input  2  valid bytes minus 1 (0 = 1 byte, 3 = 4 bytes), low lanes valid.
- s_axis_tvalid  input  1  word valid.
- s_axis_tuser  input  1  MAC error flag for this word.
- s_axis_tlast  input  1  last word of frame.
- s_axis_tready  output  1  word accepted when tvalid & tready.
- data_rx_o  output  32  word to uDMA RX channel.
- data_rx_datasize_o  output  2  fixed 2'b10 (word).
- data_rx_valid_o  output  1  output word valid.
- data_rx_ready_i  input  1  uDMA accepts word.
- frame_done_o  output  1  one-cycle pulse when status word is accepted.
- frame_cnt_o  output  16  frames reported; wraps.
- err_cnt_o  output  16  frames reported with error or truncation; wraps.
- drop_cnt_o  output  16  frames discarded while disabled; wraps.

Behaviour:
- Clock and reset: one clock clk_i. Reset rstn_i is synchronous, active-low, and takes priority over all other activity.
- Reset values: state=FRAME, sof=1, data_rx_valid_o=0, data_rx_o=0, s_axis_tready=0, frame_done_o=0, all counters=0, length=0, err=0, trunc=0.
- Output register: single stage. A new word may load when !data_rx_valid_o or data_rx_ready_i. data_rx_valid_o stays high until handshake; data_rx_o is held stable while valid & !ready.
- Write-data alignment: lanes above byte_count are zeroed in forwarded words.
- FRAME state:
  - s_axis_tready = load-allowed.
  - First word with sof=1 samples cfg_en_i. If 0, go to DISCARD processing for that word; drop_cnt increments on its tlast.
  - Each accepted word: length += byte_count+1, saturating at 2^LEN_WIDTH-1; err |= tuser.
  - Word is forwarded if the pre-add length < MAX_FRAME_BYTES; otherwise it is consumed without output and trunc=1.
  - On tlast, go to STATUS; sof=1.
- DISCARD state:
  - s_axis_tready=1; nothing is forwarded.
  - On tlast: drop_cnt++, sof=1, return to FRAME.
  - A single-word disabled frame increments drop_cnt in the cycle it is accepted.
- STATUS state:
  - s_axis_tready=0.
  - Load status word = {err, trunc, 14'b0, length} when the output register is free.
  - frame_done_o pulses on its handshake.
  - frame_cnt++, and err_cnt++ if err|trunc.
  - Clear length, err, trunc; return to FRAME.
- Latency: 1 cycle from input handshake to data_rx_valid_o. The status word follows the last forwarded data word with no bubble when data_rx_ready_i stays high.
- Simultaneous events:
  - tlast word truncated: no data output, status still emitted.
  - cfg_en_i toggling mid-frame has no effect until the next sof.
- Zero-length frames are impossible (tlast always carries ≥1 byte).
- Reset mid-frame: everything clears; the next accepted word is treated as sof. Upstream remainder then forms a frame whose status length counts only post-reset words.

Decomposition:
- Shared package eth_rx_pkg:
  - state enum {FRAME, DISCARD, STATUS}
  - status bit positions: ERR_BIT=31, TRUNC_BIT=30, LEN_LSB=0
  - UDMA_SIZE_WORD=2'b10
- One natural sub-module: eth_rx_out_reg, the single-stage valid/ready output register with hold-on-stall.

Test Plan:
- Enabled 64-byte frame (16 words, last byte_count=3), ready=1 → 16 data words then status 0x00000040, frame_done_o one pulse, frame_cnt_o=1.
- 61-byte frame, last byte_count=0, tdata=0xAABBCCDD on last word → last output 0x000000DD, status 0x0000003D.
- MAX_FRAME_BYTES=8, 16-byte frame → 2 data words forwarded, remaining consumed, status 0x40000010, err_cnt_o=1.
- tuser=1 on word 3 of 12-byte frame, ready toggling 1/0 every cycle → all 3 words intact and held while stalled, status 0x8000000C, err_cnt_o=1.
- cfg_en_i=0 at sof, 20-byte frame, then cfg_en_i=1 mid-frame → no output, drop_cnt_o=1; next frame forwarded normally.
- Assert rstn_i for one cycle after word 2 of 5 → outputs at reset values next cycle; following 3 words yield status length 12 (byte_count=3 each).
